alu_operand_collector: RTL and testbench
========================================

# alu_operand_collector

Upstream staging stage for the ALU. It accepts operand beats that may arrive split across cycles (OPA and OPB flagged separately by INP_VALID). It holds the command context until every operand the command needs is present, then issues one registered, complete request to the ALU input port. Incomplete requests are discarded with an error pulse after a bounded wait.

## Interface
Parameters:
- WIDTH, 8, operand width
- CMD_WIDTH, 3, command field is CMD_WIDTH+1 bits
- TIMEOUT, 16, number of CE-qualified cycles a partial request may wait

Ports:
- clk  in  1  clock, rising-edge
- rst  in  1  reset, asynchronous, active-low
- CE  in  1  clock enable; beats and the timeout counter advance only when CE=1
- MODE_IN  in  1  1=arithmetic, 0=logical
- CMD_IN  in  CMD_WIDTH+1  command
- CIN_IN  in  1  carry in
- OPA_IN, OPB_IN  in  WIDTH  operands
- INP_VALID_IN  in  2  bit0=OPA valid, bit1=OPB valid
- OPA, OPB  out  WIDTH  issued operands
- CMD  out  CMD_WIDTH+1  issued command
- MODE, CIN  out  1  issued context
- INP_VALID  out  2  issued operand mask; 00 when not issuing
- ISSUE  out  1  one-cycle pulse, request valid this cycle
- TIMEOUT_ERR  out  1  one-cycle pulse, partial request discarded
- BUSY  out  1  partial request held (WAIT state)

## Operation
- Required mask req(MODE, CMD):
  - Arithmetic: CMD 0–3, 8–10 → 11; CMD 4–5 → 01; CMD 6–7 → 10.
  - Logical: CMD 0–5, 12, 13 → 11; CMD 6, 8, 9 → 01; CMD 7, 10, 11 → 10.
  - Any other CMD → 00. The request is forwarded immediately with the received mask, and the ALU flags ERR.
- FSM states: IDLE, WAIT.
- IDLE: a beat is a cycle with CE=1 and INP_VALID_IN≠00.
  - On a beat, capture MODE_IN, CMD_IN and CIN_IN, plus each flagged operand.
  - If the held mask covers req, issue. Otherwise go to WAIT with counter=0.
- WAIT: beats contribute operands only; CMD_IN, MODE_IN and CIN_IN are ignored.
  - A re-delivered operand overwrites the held copy (last wins).
  - Completion → issue, then IDLE.
  - Each CE=1 cycle without completion increments the counter.
  - If that cycle is counter==TIMEOUT-1, pulse TIMEOUT_ERR, discard the request and go to IDLE.
- Issue: register OPA, OPB, CMD, MODE and CIN. Set INP_VALID=req (or the received mask for an invalid CMD) and ISSUE=1 for exactly one cycle.
  - An operand not in the issued mask is driven as 0.
- Between issues: INP_VALID=00 and ISSUE=0; OPA, OPB, CMD, MODE and CIN hold their last issued values.
- CE=0: no capture, no counter advance, and state is held. Pending ISSUE/TIMEOUT_ERR pulses still deassert.
- Counter width: $clog2(TIMEOUT+1).

## Timing
- Reset (rst=0, asynchronous): state IDLE, counter 0. All outputs 0, including INP_VALID=00, ISSUE=0, TIMEOUT_ERR=0 and BUSY=0.
- Latency: a completing beat sampled at edge N gives ISSUE=1 with outputs valid from edge N to N+1.
- Throughput: one issue per cycle for single-beat requests. The issue cycle is in IDLE and may accept the next beat.
- Split request: issues one cycle after the completing beat.
- Completion on the final permitted cycle (counter==TIMEOUT-1) wins over timeout.
- BUSY=1 exactly while in WAIT. It drops in the cycle ISSUE or TIMEOUT_ERR is high.
- Reset asserted mid-WAIT discards the request. No ISSUE or TIMEOUT_ERR follows release.
- All outputs are registered; there is no combinational path from input to output.

## Structure
- The shared package holds:
  - the arithmetic/logical CMD encodings as constants;
  - the INP_VALID encodings NONE=00, A=01, B=10, AB=11;
  - the state enum;
  - a function `req_mask(mode, cmd)`, reused by the reference model and scoreboard.
- No sub-module. One FSM plus a capture register set plus the counter.

## Test plan
- Reset: rst=0 with random inputs → all outputs 0, BUSY=0.
- MODE=1, CMD=0, INP_VALID_IN=11, OPA_IN=0x0F, OPB_IN=0x01, CE=1 → next cycle ISSUE=1, OPA=0x0F, OPB=0x01, CMD=0, INP_VALID=11.
- Split request:
  - MODE=1, CMD=0, INP_VALID_IN=01, OPA_IN=0x10.
  - 3 cycles idle, then INP_VALID_IN=10, OPB_IN=0x20, CMD_IN=5.
  - Required: BUSY=1 for 4 cycles, then ISSUE with OPA=0x10, OPB=0x20, CMD=0.
- Single-operand: MODE=1, CMD=4, INP_VALID_IN=01, OPA_IN=0xFF → ISSUE next cycle, INP_VALID=01, OPB=0, BUSY stays 0.
- Timeout:
  - MODE=0, CMD=0, INP_VALID_IN=10, then no beats, TIMEOUT=16.
  - Required: TIMEOUT_ERR pulses in the 16th CE cycle of WAIT, no ISSUE.
  - Repeat with CE toggling 0/1: the pulse is delayed by the number of CE=0 cycles.
- Reset mid-WAIT: rst=0 two cycles after a partial beat → BUSY=0 immediately; after release, no ISSUE or TIMEOUT_ERR.

Source files
------------

// File: rtl/alu_operand_collector_pkg.sv
// Shared definitions for the ALU operand collector: command encodings,
// operand-valid mask encodings, FSM state type and the required-operand lookup.
package alu_operand_collector_pkg;

  // Arithmetic command encodings (MODE=1)
  localparam int unsigned ARITH_ADD     = 0;
  localparam int unsigned ARITH_SUB     = 1;
  localparam int unsigned ARITH_ADD_CIN = 2;
  localparam int unsigned ARITH_SUB_CIN = 3;
  localparam int unsigned ARITH_INC_A   = 4;
  localparam int unsigned ARITH_DEC_A   = 5;
  localparam int unsigned ARITH_INC_B   = 6;
  localparam int unsigned ARITH_DEC_B   = 7;
  localparam int unsigned ARITH_CMP     = 8;
  localparam int unsigned ARITH_INC_MUL = 9;
  localparam int unsigned ARITH_SHL_MUL = 10;

  // Logical command encodings (MODE=0)
  localparam int unsigned LOGIC_AND    = 0;
  localparam int unsigned LOGIC_NAND   = 1;
  localparam int unsigned LOGIC_OR     = 2;
  localparam int unsigned LOGIC_NOR    = 3;
  localparam int unsigned LOGIC_XOR    = 4;
  localparam int unsigned LOGIC_XNOR   = 5;
  localparam int unsigned LOGIC_NOT_A  = 6;
  localparam int unsigned LOGIC_NOT_B  = 7;
  localparam int unsigned LOGIC_SHR1_A = 8;
  localparam int unsigned LOGIC_SHL1_A = 9;
  localparam int unsigned LOGIC_SHR1_B = 10;
  localparam int unsigned LOGIC_SHL1_B = 11;
  localparam int unsigned LOGIC_ROL    = 12;
  localparam int unsigned LOGIC_ROR    = 13;

  // Operand-valid mask encodings: bit0 = OPA, bit1 = OPB
  localparam logic [1:0] VALID_NONE = 2'b00;
  localparam logic [1:0] VALID_A    = 2'b01;
  localparam logic [1:0] VALID_B    = 2'b10;
  localparam logic [1:0] VALID_AB   = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  // Operands a command needs; VALID_NONE marks a command the ALU will reject
  function automatic logic [1:0] req_mask(input logic mode, input int unsigned cmd);
    logic [1:0] mask;
    mask = VALID_NONE;
    if (mode) begin
      case (cmd)
        ARITH_ADD, ARITH_SUB, ARITH_ADD_CIN, ARITH_SUB_CIN,
        ARITH_CMP, ARITH_INC_MUL, ARITH_SHL_MUL: mask = VALID_AB;
        ARITH_INC_A, ARITH_DEC_A:               mask = VALID_A;
        ARITH_INC_B, ARITH_DEC_B:               mask = VALID_B;
        default:                                mask = VALID_NONE;
      endcase
    end else begin
      case (cmd)
        LOGIC_AND, LOGIC_NAND, LOGIC_OR, LOGIC_NOR, LOGIC_XOR,
        LOGIC_XNOR, LOGIC_ROL, LOGIC_ROR:         mask = VALID_AB;
        LOGIC_NOT_A, LOGIC_SHR1_A, LOGIC_SHL1_A:  mask = VALID_A;
        LOGIC_NOT_B, LOGIC_SHR1_B, LOGIC_SHL1_B:  mask = VALID_B;
        default:                                  mask = VALID_NONE;
      endcase
    end
    return mask;
  endfunction

endpackage

// File: rtl/alu_operand_collector.sv
// Operand collector in front of the ALU: gathers split OPA/OPB beats under one
// command context, issues a single registered request once complete, and drops
// a partial request with TIMEOUT_ERR after TIMEOUT enabled cycles of waiting.
module alu_operand_collector
  import alu_operand_collector_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int CMD_WIDTH = 3,
  parameter int TIMEOUT   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 CE,
  input  logic                 MODE_IN,
  input  logic [CMD_WIDTH:0]   CMD_IN,
  input  logic                 CIN_IN,
  input  logic [WIDTH-1:0]     OPA_IN,
  input  logic [WIDTH-1:0]     OPB_IN,
  input  logic [1:0]           INP_VALID_IN,
  output logic [WIDTH-1:0]     OPA,
  output logic [WIDTH-1:0]     OPB,
  output logic [CMD_WIDTH:0]   CMD,
  output logic                 MODE,
  output logic                 CIN,
  output logic [1:0]           INP_VALID,
  output logic                 ISSUE,
  output logic                 TIMEOUT_ERR,
  output logic                 BUSY
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e             state, state_next;
  logic [WIDTH-1:0]   held_a, held_a_next, held_b, held_b_next;
  logic [CMD_WIDTH:0] held_cmd, held_cmd_next;
  logic               held_mode, held_mode_next, held_cin, held_cin_next;
  logic [1:0]         held_mask, held_mask_next;
  logic [CNT_W-1:0]   count, count_next;

  logic               beat;
  logic [1:0]         req_new, req_held, merged_mask;
  logic [WIDTH-1:0]   merged_a, merged_b;

  logic               do_issue, do_timeout;
  logic [WIDTH-1:0]   iss_a, iss_b;
  logic [CMD_WIDTH:0] iss_cmd;
  logic               iss_mode, iss_cin;
  logic [1:0]         iss_mask;

  assign beat        = CE && (INP_VALID_IN != VALID_NONE);
  assign req_new     = req_mask(MODE_IN, 32'(CMD_IN));
  assign req_held    = req_mask(held_mode, 32'(held_cmd));
  assign merged_a    = INP_VALID_IN[0] ? OPA_IN : held_a;
  assign merged_b    = INP_VALID_IN[1] ? OPB_IN : held_b;
  assign merged_mask = held_mask | INP_VALID_IN;

  // Next-state logic: decide between immediate issue, waiting, completion and timeout
  always_comb begin
    state_next     = state;
    held_a_next    = held_a;
    held_b_next    = held_b;
    held_cmd_next  = held_cmd;
    held_mode_next = held_mode;
    held_cin_next  = held_cin;
    held_mask_next = held_mask;
    count_next     = count;
    do_issue       = 1'b0;
    do_timeout     = 1'b0;
    iss_a          = held_a;
    iss_b          = held_b;
    iss_cmd        = held_cmd;
    iss_mode       = held_mode;
    iss_cin        = held_cin;
    iss_mask       = VALID_NONE;
    case (state)
      ST_IDLE: begin
        if (beat) begin
          if ((INP_VALID_IN & req_new) == req_new) begin
            do_issue = 1'b1;
            iss_a    = OPA_IN;
            iss_b    = OPB_IN;
            iss_cmd  = CMD_IN;
            iss_mode = MODE_IN;
            iss_cin  = CIN_IN;
            iss_mask = (req_new == VALID_NONE) ? INP_VALID_IN : req_new;
          end else begin
            state_next     = ST_WAIT;
            count_next     = '0;
            held_a_next    = OPA_IN;
            held_b_next    = OPB_IN;
            held_cmd_next  = CMD_IN;
            held_mode_next = MODE_IN;
            held_cin_next  = CIN_IN;
            held_mask_next = INP_VALID_IN;
          end
        end
      end
      ST_WAIT: begin
        if (CE) begin
          if ((merged_mask & req_held) == req_held) begin
            do_issue   = 1'b1;
            iss_a      = merged_a;
            iss_b      = merged_b;
            iss_mask   = req_held;
            state_next = ST_IDLE;
            count_next = '0;
          end else if (count == CNT_LAST) begin
            do_timeout = 1'b1;
            state_next = ST_IDLE;
            count_next = '0;
          end else begin
            count_next     = count + CNT_W'(1);
            held_a_next    = merged_a;
            held_b_next    = merged_b;
            held_mask_next = merged_mask;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State, captured context and wait counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      held_a    <= '0;
      held_b    <= '0;
      held_cmd  <= '0;
      held_mode <= 1'b0;
      held_cin  <= 1'b0;
      held_mask <= VALID_NONE;
      count     <= '0;
    end else begin
      state     <= state_next;
      held_a    <= held_a_next;
      held_b    <= held_b_next;
      held_cmd  <= held_cmd_next;
      held_mode <= held_mode_next;
      held_cin  <= held_cin_next;
      held_mask <= held_mask_next;
      count     <= count_next;
    end
  end

  // Registered ALU-facing outputs; payload holds between issues, pulses self-clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      OPA         <= '0;
      OPB         <= '0;
      CMD         <= '0;
      MODE        <= 1'b0;
      CIN         <= 1'b0;
      INP_VALID   <= VALID_NONE;
      ISSUE       <= 1'b0;
      TIMEOUT_ERR <= 1'b0;
      BUSY        <= 1'b0;
    end else begin
      ISSUE       <= do_issue;
      TIMEOUT_ERR <= do_timeout;
      BUSY        <= (state_next == ST_WAIT);
      INP_VALID   <= do_issue ? iss_mask : VALID_NONE;
      if (do_issue) begin
        OPA  <= iss_mask[0] ? iss_a : '0;
        OPB  <= iss_mask[1] ? iss_b : '0;
        CMD  <= iss_cmd;
        MODE <= iss_mode;
        CIN  <= iss_cin;
      end
    end
  end

endmodule

// File: tb/tb_alu_operand_collector.sv
// Scoreboard bench for alu_operand_collector: directed beats push expected
// issues/timeouts (with the cycle they must appear in) and a negedge monitor
// pops and compares whenever ISSUE or TIMEOUT_ERR is seen.
module tb_alu_operand_collector;
  import alu_operand_collector_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       CE = 1'b0;
  logic       MODE_IN = 1'b0;
  logic [3:0] CMD_IN = 4'd0;
  logic       CIN_IN = 1'b0;
  logic [7:0] OPA_IN = 8'h00;
  logic [7:0] OPB_IN = 8'h00;
  logic [1:0] INP_VALID_IN = 2'b00;
  logic [7:0] OPA, OPB;
  logic [3:0] CMD;
  logic       MODE, CIN, ISSUE, TIMEOUT_ERR, BUSY;
  logic [1:0] INP_VALID;

  typedef struct {
    int         cyc;
    bit         timeout;
    logic [1:0] mask;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] cmd;
    logic       mode;
    logic       cin;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  alu_operand_collector #(.WIDTH(8), .CMD_WIDTH(3), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .CE(CE), .MODE_IN(MODE_IN), .CMD_IN(CMD_IN),
    .CIN_IN(CIN_IN), .OPA_IN(OPA_IN), .OPB_IN(OPB_IN), .INP_VALID_IN(INP_VALID_IN),
    .OPA(OPA), .OPB(OPB), .CMD(CMD), .MODE(MODE), .CIN(CIN),
    .INP_VALID(INP_VALID), .ISSUE(ISSUE), .TIMEOUT_ERR(TIMEOUT_ERR), .BUSY(BUSY)
  );

  always #5 clk = ~clk;

  // Edge counter used to time-stamp expected outputs
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic ce, input logic mode, input logic [3:0] cmd,
                               input logic cin, input logic [1:0] valid,
                               input logic [7:0] a, input logic [7:0] b);
    CE = ce; MODE_IN = mode; CMD_IN = cmd; CIN_IN = cin;
    INP_VALID_IN = valid; OPA_IN = a; OPB_IN = b;
    @(negedge clk);
  endtask

  task automatic idleCycles(input int n, input logic ce);
    for (int i = 0; i < n; i++) applyStimulus(ce, 1'b0, 4'd0, 1'b0, 2'b00, 8'h00, 8'h00);
  endtask

  // Expect an issue produced by the beat about to be applied
  task automatic expectIssue(input logic [1:0] mask, input logic [7:0] a, input logic [7:0] b,
                             input logic [3:0] cmd, input logic mode, input logic cin);
    exp_t e;
    e.cyc = cyc + 1; e.timeout = 1'b0; e.mask = mask; e.a = a; e.b = b;
    e.cmd = cmd; e.mode = mode; e.cin = cin;
    sb.push_back(e);
  endtask

  task automatic expectTimeout(input int at_cyc);
    exp_t e;
    e.cyc = at_cyc; e.timeout = 1'b1; e.mask = 2'b00; e.a = 8'h00; e.b = 8'h00;
    e.cmd = 4'd0; e.mode = 1'b0; e.cin = 1'b0;
    sb.push_back(e);
  endtask

  // Monitor: pop and compare on every ISSUE/TIMEOUT_ERR, and police the idle mask
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      if (!ISSUE) begin
        checks++;
        if (INP_VALID !== 2'b00) begin
          errors++;
          $display("[TB] FAIL idle_mask: INP_VALID=%b required 00 at cyc %0d", INP_VALID, cyc);
        end
      end
      if (ISSUE || TIMEOUT_ERR) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_output: ISSUE=%b TIMEOUT_ERR=%b at cyc %0d, none required",
                   ISSUE, TIMEOUT_ERR, cyc);
        end else begin
          e = sb.pop_front();
          if (e.timeout) begin
            if (cyc != e.cyc || ISSUE !== 1'b0 || TIMEOUT_ERR !== 1'b1 || INP_VALID !== 2'b00) begin
              errors++;
              $display("[TB] FAIL timeout: got cyc=%0d ISSUE=%b TIMEOUT_ERR=%b INP_VALID=%b, required cyc=%0d ISSUE=0 TIMEOUT_ERR=1 INP_VALID=00",
                       cyc, ISSUE, TIMEOUT_ERR, INP_VALID, e.cyc);
            end
          end else begin
            if (cyc != e.cyc || ISSUE !== 1'b1 || TIMEOUT_ERR !== 1'b0 || INP_VALID !== e.mask ||
                OPA !== e.a || OPB !== e.b || CMD !== e.cmd || MODE !== e.mode || CIN !== e.cin) begin
              errors++;
              $display("[TB] FAIL issue: got cyc=%0d ISSUE=%b TERR=%b mask=%b A=%h B=%h CMD=%0d MODE=%b CIN=%b, required cyc=%0d mask=%b A=%h B=%h CMD=%0d MODE=%b CIN=%b",
                       cyc, ISSUE, TIMEOUT_ERR, INP_VALID, OPA, OPB, CMD, MODE, CIN,
                       e.cyc, e.mask, e.a, e.b, e.cmd, e.mode, e.cin);
            end
          end
        end
      end
    end
  end

  initial begin
    // Reset with random inputs: every output must stay zero
    for (int i = 0; i < 3; i++) begin
      CE = 1'($urandom); MODE_IN = 1'($urandom); CMD_IN = 4'($urandom); CIN_IN = 1'($urandom);
      OPA_IN = 8'($urandom); OPB_IN = 8'($urandom); INP_VALID_IN = 2'($urandom);
      @(negedge clk);
    end
    checkOutput("reset_outputs", 64'({OPA, OPB, CMD, MODE, CIN, INP_VALID, ISSUE, TIMEOUT_ERR, BUSY}), 64'd0);
    CE = 1'b1; INP_VALID_IN = 2'b00;
    rst = 1'b1;
    @(negedge clk);

    // Full beat issues on the next cycle
    expectIssue(2'b11, 8'h0F, 8'h01, 4'd0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 4'd0, 1'b0, 2'b11, 8'h0F, 8'h01);
    checkOutput("basic_busy", 64'(BUSY), 64'd0);

    // Back-to-back single-beat requests, one of which needs only OPA
    expectIssue(2'b11, 8'h33, 8'h11, 4'd1, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 4'd1, 1'b1, 2'b11, 8'h33, 8'h11);
    expectIssue(2'b11, 8'hAA, 8'h55, 4'd2, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'd2, 1'b0, 2'b11, 8'hAA, 8'h55);
    expectIssue(2'b01, 8'h3C, 8'h00, 4'd6, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 4'd6, 1'b1, 2'b11, 8'h3C, 8'hC3);
    idleCycles(2, 1'b1);

    // Split request: context comes from the first beat only
    applyStimulus(1'b1, 1'b1, 4'd0, 1'b1, 2'b01, 8'h10, 8'h00);
    checkOutput("split_busy_0", 64'(BUSY), 64'd1);
    for (int i = 1; i <= 3; i++) begin
      idleCycles(1, 1'b1);
      checkOutput("split_busy", 64'(BUSY), 64'd1);
    end
    expectIssue(2'b11, 8'h10, 8'h20, 4'd0, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 4'd5, 1'b0, 2'b10, 8'hEE, 8'h20);
    checkOutput("split_busy_done", 64'(BUSY), 64'd0);

    // Single-operand arithmetic: OPB driven as zero
    expectIssue(2'b01, 8'hFF, 8'h00, 4'd4, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 4'd4, 1'b0, 2'b01, 8'hFF, 8'h77);
    checkOutput("single_busy", 64'(BUSY), 64'd0);

    // Re-delivered operand in WAIT: last copy wins
    applyStimulus(1'b1, 1'b1, 4'd8, 1'b0, 2'b01, 8'h11, 8'h00);
    applyStimulus(1'b1, 1'b1, 4'd8, 1'b0, 2'b01, 8'h22, 8'h00);
    expectIssue(2'b11, 8'h22, 8'h33, 4'd8, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 4'd8, 1'b0, 2'b10, 8'h99, 8'h33);

    // Invalid commands forward immediately with the received mask
    expectIssue(2'b10, 8'h00, 8'h5A, 4'd12, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 4'd12, 1'b0, 2'b10, 8'hA5, 8'h5A);
    expectIssue(2'b01, 8'hC7, 8'h00, 4'd14, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 4'd14, 1'b1, 2'b01, 8'hC7, 8'hB2);

    // Beat with CE=0 is ignored entirely
    applyStimulus(1'b0, 1'b1, 4'd0, 1'b0, 2'b11, 8'h12, 8'h34);
    checkOutput("ce0_busy", 64'(BUSY), 64'd0);
    idleCycles(2, 1'b1);

    // Timeout with CE held high: 16 WAIT cycles, then the error pulse
    expectTimeout(cyc + 17);
    applyStimulus(1'b1, 1'b0, 4'd0, 1'b0, 2'b10, 8'h00, 8'h44);
    checkOutput("to_busy_start", 64'(BUSY), 64'd1);
    for (int i = 1; i <= 20; i++) begin
      idleCycles(1, 1'b1);
      checkOutput("to_busy", 64'(BUSY), 64'(i < 16));
    end

    // Timeout with CE toggling: delayed by the 16 CE=0 cycles
    expectTimeout(cyc + 33);
    applyStimulus(1'b1, 1'b0, 4'd0, 1'b0, 2'b10, 8'h00, 8'h44);
    for (int i = 1; i <= 40; i++) begin
      idleCycles(1, (i % 2) == 0);
      checkOutput("to_ce_busy", 64'(BUSY), 64'(i < 32));
    end

    // Completion on the last permitted cycle beats the timeout
    applyStimulus(1'b1, 1'b0, 4'd13, 1'b0, 2'b01, 8'h81, 8'h00);
    idleCycles(15, 1'b1);
    checkOutput("last_cycle_busy", 64'(BUSY), 64'd1);
    expectIssue(2'b11, 8'h81, 8'h03, 4'd13, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 4'd2, 1'b1, 2'b10, 8'h00, 8'h03);
    checkOutput("last_cycle_done", 64'(BUSY), 64'd0);
    idleCycles(20, 1'b1);

    // Reset mid-WAIT: BUSY drops at once, nothing follows release
    applyStimulus(1'b1, 1'b1, 4'd0, 1'b0, 2'b01, 8'h42, 8'h00);
    idleCycles(1, 1'b1);
    #2 rst = 1'b0;
    #1 checkOutput("rst_wait_outputs", 64'({BUSY, ISSUE, TIMEOUT_ERR, INP_VALID}), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    idleCycles(20, 1'b1);
    checkOutput("rst_wait_busy", 64'(BUSY), 64'd0);

    idleCycles(3, 1'b1);
    checkOutput("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
